wb_stage: RTL and testbench

Writeback stage of the pipelined MIPS core: the writer side of the register file. Registers the MEM-stage result (MEM/WB pipeline register), formats load data, selects the write-back value and drives the register file write port (`regwrite`, `rd`, `write_data`), which the forwarding unit also taps. Also keeps a retired-instruction counter and captures misaligned-load faults.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/load_align.sv | 50 +++++
 rtl/wb_stage.sv | 123 ++++++++++++
 tb/tb_wb_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants, load-size encodings and alignment helper.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_BYTE = 2'b10;

  // True when an access of the given size is not naturally aligned.
  // Size 2'b11 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic bad;
    bad = 1'b0;
    case (size)
      LD_BYTE: bad = 1'b0;
      LD_HALF: bad = addr[0];
      default: bad = (addr != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed byte/half lane of a
// little-endian memory word and sign- or zero-extends it to DATA_W.
// Ports:
//   rdata_i    - raw data-memory word
//   addr_i     - low address bits (byte lane)
//   size_i     - LD_WORD / LD_HALF / LD_BYTE (2'b11 acts as word)
//   unsigned_i - zero-extend instead of sign-extend
//   data_c     - formatted word (combinational)
module load_align
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        addr_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        ext_bit;

  always_comb begin
    byte_sel = rdata_i[7:0];
    half_sel = rdata_i[15:0];
    ext_bit  = 1'b0;
    data_c   = rdata_i;

    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      LD_BYTE: begin
        ext_bit = ~unsigned_i & byte_sel[7];
        data_c  = {{(DATA_W-8){ext_bit}}, byte_sel};
      end
      LD_HALF: begin
        ext_bit = ~unsigned_i & half_sel[15];
        data_c  = {{(DATA_W-16){ext_bit}}, half_sel};
      end
      default: data_c = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load formatting, result select,
// register-file write port, retired-instruction counter and misaligned-load
// fault capture. All outputs are registered.
// Ports:
//   clk, rst (sync, active-low)
//   mem_*       - instruction presented by MEM this cycle
//   wb_flush    - squash the entering instruction
//   exc_clear   - clear the sticky misalign flag
//   regwrite/rd/write_data - register-file write port
//   wb_valid    - WB holds a live instruction
//   instret     - retired-instruction count
//   misalign/badaddr - sticky fault flag and first faulting address
module wb_stage
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic                  mem_memtoreg,
  input  logic                  mem_link,
  input  logic [1:0]            mem_ld_size,
  input  logic                  mem_ld_unsigned,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic [DATA_W-1:0]     mem_pc,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_flush,
  input  logic                  exc_clear,
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [DATA_W-1:0]     write_data,
  output logic                  wb_valid,
  output logic [31:0]           instret,
  output logic                  misalign,
  output logic [DATA_W-1:0]     badaddr
);

  logic                  regwrite_q,   regwrite_d;
  logic [REG_ADDR_W-1:0] rd_q,         rd_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;
  logic                  wb_valid_q,   wb_valid_d;
  logic [31:0]           instret_q,    instret_d;
  logic                  misalign_q,   misalign_d;
  logic [DATA_W-1:0]     badaddr_q,    badaddr_d;

  logic [DATA_W-1:0] load_data_c;
  logic              live;
  logic              fault;
  logic              entry;

  load_align u_load_align (
    .rdata_i    (mem_rdata),
    .addr_i     (mem_alu_result[1:0]),
    .size_i     (mem_ld_size),
    .unsigned_i (mem_ld_unsigned),
    .data_c     (load_data_c)
  );

  // Entry qualification, result select, counter and fault next-state.
  always_comb begin
    live         = mem_valid & ~wb_flush;
    fault        = live & mem_memtoreg & is_misaligned(mem_ld_size, mem_alu_result[1:0]);
    entry        = live & ~fault;

    wb_valid_d   = entry;
    regwrite_d   = entry & mem_regwrite & (mem_rd != REG_ZERO);
    rd_d         = mem_rd;
    write_data_d = mem_alu_result;
    instret_d    = instret_q;
    misalign_d   = misalign_q;
    badaddr_d    = badaddr_q;

    if (mem_link) begin
      write_data_d = mem_pc + DATA_W'(8);
    end else if (mem_memtoreg) begin
      write_data_d = load_data_c;
    end

    if (entry) begin
      instret_d = instret_q + 32'(1);
    end

    // A fresh fault wins over a simultaneous clear; otherwise only the
    // first fault since the last clear is recorded.
    if (fault && (!misalign_q || exc_clear)) begin
      misalign_d = 1'b1;
      badaddr_d  = mem_alu_result;
    end else if (exc_clear) begin
      misalign_d = 1'b0;
    end
  end

  // MEM/WB register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regwrite_q   <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      wb_valid_q   <= 1'b0;
      instret_q    <= '0;
      misalign_q   <= 1'b0;
      badaddr_q    <= '0;
    end else begin
      regwrite_q   <= regwrite_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
      wb_valid_q   <= wb_valid_d;
      instret_q    <= instret_d;
      misalign_q   <= misalign_d;
      badaddr_q    <= badaddr_d;
    end
  end

  assign regwrite   = regwrite_q;
  assign rd         = rd_q;
  assign write_data = write_data_q;
  assign wb_valid   = wb_valid_q;
  assign instret    = instret_q;
  assign misalign   = misalign_q;
  assign badaddr    = badaddr_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: each step drives one MEM instruction, pushes
// the expected WB outputs to a scoreboard queue, and pops/compares them one
// cycle later.
module tb_wb_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_regwrite, mem_memtoreg, mem_link;
  logic [1:0]  mem_ld_size;
  logic        mem_ld_unsigned;
  logic [31:0] mem_alu_result, mem_rdata, mem_pc;
  logic [4:0]  mem_rd;
  logic        wb_flush, exc_clear;
  logic        regwrite;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        wb_valid;
  logic [31:0] instret;
  logic        misalign;
  logic [31:0] badaddr;

  typedef struct {
    string       tag;
    logic        chk_data;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        wb_valid;
    logic [31:0] instret;
    logic        misalign;
    logic [31:0] badaddr;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_instret = '0;
  logic        m_mis     = 1'b0;
  logic [31:0] m_bad     = '0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk             (clk),
    .rst             (rst),
    .mem_valid       (mem_valid),
    .mem_regwrite    (mem_regwrite),
    .mem_memtoreg    (mem_memtoreg),
    .mem_link        (mem_link),
    .mem_ld_size     (mem_ld_size),
    .mem_ld_unsigned (mem_ld_unsigned),
    .mem_alu_result  (mem_alu_result),
    .mem_rdata       (mem_rdata),
    .mem_pc          (mem_pc),
    .mem_rd          (mem_rd),
    .wb_flush        (wb_flush),
    .exc_clear       (exc_clear),
    .regwrite        (regwrite),
    .rd              (rd),
    .write_data      (write_data),
    .wb_valid        (wb_valid),
    .instret         (instret),
    .misalign        (misalign),
    .badaddr         (badaddr)
  );

  task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, field, obs, exp);
    end
  endtask

  // One instruction: drive at negedge, push expectation, compare after posedge.
  task automatic step(input string tag, input logic r, input logic v, input logic rw,
                      input logic m2r, input logic lnk, input logic [1:0] sz, input logic un,
                      input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc,
                      input logic [4:0] rdi, input logic fl, input logic clr,
                      input logic [31:0] exp_wd);
    exp_t e;
    exp_t got;
    logic live, bad, entry;
    @(negedge clk);
    rst = r; mem_valid = v; mem_regwrite = rw; mem_memtoreg = m2r; mem_link = lnk;
    mem_ld_size = sz; mem_ld_unsigned = un; mem_alu_result = alu; mem_rdata = rdat;
    mem_pc = pc; mem_rd = rdi; wb_flush = fl; exc_clear = clr;

    live = v & ~fl;
    bad  = 1'b0;
    if (m2r) begin
      if (sz == 2'b01)      bad = alu[0];
      else if (sz != 2'b10) bad = (alu[1:0] != 2'b00);
    end
    bad   = bad & live;
    entry = live & ~bad;
    e.tag = tag;
    if (!r) begin
      m_instret = '0; m_mis = 1'b0; m_bad = '0;
      e.chk_data = 1'b1; e.regwrite = 1'b0; e.rd = '0; e.wd = '0; e.wb_valid = 1'b0;
    end else begin
      if (entry) m_instret = m_instret + 32'd1;
      if (bad && (!m_mis || clr)) begin
        m_mis = 1'b1; m_bad = alu;
      end else if (clr) begin
        m_mis = 1'b0;
      end
      e.wb_valid = entry;
      e.regwrite = entry & rw & (rdi != 5'd0);
      e.chk_data = e.regwrite;
      e.rd = rdi;
      e.wd = exp_wd;
    end
    e.instret  = m_instret;
    e.misalign = m_mis;
    e.badaddr  = m_bad;
    sb.push_back(e);

    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk(got.tag, "regwrite", 32'(regwrite), 32'(got.regwrite));
    chk(got.tag, "wb_valid", 32'(wb_valid), 32'(got.wb_valid));
    chk(got.tag, "instret", instret, got.instret);
    chk(got.tag, "misalign", 32'(misalign), 32'(got.misalign));
    chk(got.tag, "badaddr", badaddr, got.badaddr);
    if (got.chk_data) begin
      chk(got.tag, "rd", 32'(rd), 32'(got.rd));
      chk(got.tag, "write_data", write_data, got.wd);
    end
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;

  initial begin
    rst = 1'b0; mem_valid = 1'b0; mem_regwrite = 1'b0; mem_memtoreg = 1'b0; mem_link = 1'b0;
    mem_ld_size = 2'b00; mem_ld_unsigned = 1'b0; mem_alu_result = '0; mem_rdata = '0;
    mem_pc = '0; mem_rd = '0; wb_flush = 1'b0; exc_clear = 1'b0;

    //    tag           rst v rw m2r lnk sz     un alu           rdata pc             rd  fl clr exp_wd
    step("reset",       0, 0, 0, 0,  0,  2'b00, 0, 32'h0,        RD,   32'h0,         0,  0, 0,  32'h0);
    step("alu",         1, 1, 1, 0,  0,  2'b00, 0, 32'h0000_1234, RD,  32'h0,         8,  0, 0,  32'h0000_1234);
    step("lb_3",        1, 1, 1, 1,  0,  2'b10, 0, 32'h0000_1003, RD,  32'h0,         9,  0, 0,  32'hFFFF_FF80);
    step("lbu_3",       1, 1, 1, 1,  0,  2'b10, 1, 32'h0000_1003, RD,  32'h0,         10, 0, 0,  32'h0000_0080);
    step("lb_1",        1, 1, 1, 1,  0,  2'b10, 0, 32'h0000_1001, RD,  32'h0,         11, 0, 0,  32'h0000_007F);
    step("lbu_0",       1, 1, 1, 1,  0,  2'b10, 1, 32'h0000_1000, RD,  32'h0,         12, 0, 0,  32'h0000_0001);
    step("lh_hi",       1, 1, 1, 1,  0,  2'b01, 0, 32'h0000_1002, RD,  32'h0,         13, 0, 0,  32'hFFFF_80FF);
    step("lhu_hi",      1, 1, 1, 1,  0,  2'b01, 1, 32'h0000_1002, RD,  32'h0,         14, 0, 0,  32'h0000_80FF);
    step("lh_lo",       1, 1, 1, 1,  0,  2'b01, 0, 32'h0000_1000, RD,  32'h0,         15, 0, 0,  32'h0000_7F01);
    step("lw",          1, 1, 1, 1,  0,  2'b00, 0, 32'h0000_1000, RD,  32'h0,         16, 0, 0,  32'h80FF_7F01);
    step("jal",         1, 1, 1, 0,  1,  2'b00, 0, 32'hDEAD_BEEF, RD,  32'h0040_0010, 31, 0, 0,  32'h0040_0018);
    step("jal_wrap",    1, 1, 1, 1,  1,  2'b00, 0, 32'h0000_0000, RD,  32'hFFFF_FFFC, 31, 0, 0,  32'h0000_0004);
    step("rd0",         1, 1, 1, 0,  0,  2'b00, 0, 32'h0000_5555, RD,  32'h0,         0,  0, 0,  32'h0000_5555);
    step("no_rw",       1, 1, 0, 0,  0,  2'b00, 0, 32'h0000_6666, RD,  32'h0,         7,  0, 0,  32'h0000_6666);
    step("flush",       1, 1, 1, 0,  0,  2'b00, 0, 32'h0000_7777, RD,  32'h0,         5,  1, 0,  32'h0000_7777);
    step("bubble",      1, 0, 1, 0,  0,  2'b00, 0, 32'h0000_8888, RD,  32'h0,         5,  0, 0,  32'h0000_8888);
    step("mis_lw",      1, 1, 1, 1,  0,  2'b00, 0, 32'h0000_0102, RD,  32'h0,         6,  0, 0,  32'h0);
    step("mis_lh2",     1, 1, 1, 1,  0,  2'b01, 0, 32'h0000_0201, RD,  32'h0,         6,  0, 0,  32'h0);
    step("mis_clr_new", 1, 1, 1, 1,  0,  2'b01, 0, 32'h0000_0301, RD,  32'h0,         6,  0, 1,  32'h0);
    step("clr_only",    1, 0, 0, 0,  0,  2'b00, 0, 32'h0,        RD,   32'h0,         0,  0, 1,  32'h0);
    step("mis_flushed", 1, 1, 1, 1,  0,  2'b00, 0, 32'h0000_0402, RD,  32'h0,         6,  1, 0,  32'h0);
    step("pending",     1, 1, 1, 0,  0,  2'b00, 0, 32'h0000_ABCD, RD,  32'h0,         3,  0, 0,  32'h0000_ABCD);
    step("mid_reset",   0, 1, 1, 0,  0,  2'b00, 0, 32'h0000_EEEE, RD,  32'h0,         4,  1, 1,  32'h0);
    step("post_reset",  1, 1, 1, 0,  0,  2'b00, 0, 32'h0000_0042, RD,  32'h0,         2,  0, 0,  32'h0000_0042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
